// File: rtl/flow_stat_ctr.sv
// flow_stat_ctr: per-flow byte/packet statistics table.
// Each table entry holds {bytes, pkts, sat}. After reset, an INIT sweep zeroes one
// entry per cycle. The block then enters RUN and accepts one update per cycle.
// Reads return their result two cycles later. A read can optionally clear the entry.
// Optional feature macro: FLOW_STAT_SAT_EN. When it is defined, the counters saturate
// and the sticky sat flag is kept. When it is undefined, the counters wrap and rd_sat is 0.
module flow_stat_ctr #(
   parameter int FLOW_W = 3,
   parameter int SIZE_W = 16,
   parameter int BYTE_W = 32,
   parameter int PKT_W  = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              upd_ena,
   input  logic [FLOW_W-1:0] upd_flow,
   input  logic [SIZE_W-1:0] upd_size,
   input  logic              rd_stb,
   input  logic [FLOW_W-1:0] rd_flow,
   input  logic              rd_clr,
   output logic              rd_val,
   output logic [BYTE_W-1:0] rd_bytes,
   output logic [PKT_W-1:0]  rd_pkts,
   output logic              rd_sat,
   output logic              init_done
);

   localparam int NFLOW = 2**FLOW_W;

   typedef enum logic {INIT, RUN} state_t;

   state_t            state;
   logic [FLOW_W-1:0] sweep_ptr;

   logic [BYTE_W-1:0] byte_tab [NFLOW];
   logic [PKT_W-1:0]  pkt_tab  [NFLOW];
   logic [NFLOW-1:0]  sat_tab;

   logic              run;
   logic              upd_go;
   logic              rd_go;
   logic              hit;

   logic [BYTE_W-1:0] byte_new;
   logic [PKT_W-1:0]  pkt_new;
   logic              sat_new;

   logic [BYTE_W-1:0] snap_bytes;
   logic [PKT_W-1:0]  snap_pkts;
   logic              snap_sat;

   logic              s1_val;
   logic [BYTE_W-1:0] s1_bytes;
   logic [PKT_W-1:0]  s1_pkts;
   logic              s1_sat;

   assign run    = (state == RUN);
   assign upd_go = upd_ena & run;
   assign rd_go  = rd_stb & run;
   assign hit    = upd_go && (upd_flow == rd_flow);

`ifdef FLOW_STAT_SAT_EN
   logic [BYTE_W:0] byte_sum;
   logic [PKT_W:0]  pkt_sum;

   // Compute the updated entry value; a carry out pins the counter at all-ones and sets sat.
   always_comb begin
      byte_sum = {1'b0, byte_tab[upd_flow]} + (BYTE_W+1)'(upd_size);
      pkt_sum  = {1'b0, pkt_tab[upd_flow]} + (PKT_W+1)'(1);
      byte_new = byte_sum[BYTE_W] ? '1 : byte_sum[BYTE_W-1:0];
      pkt_new  = pkt_sum[PKT_W] ? '1 : pkt_sum[PKT_W-1:0];
      sat_new  = sat_tab[upd_flow] | byte_sum[BYTE_W] | pkt_sum[PKT_W];
   end
`else
   // Compute the updated entry value; both counters wrap and sat never sets.
   always_comb begin
      byte_new = byte_tab[upd_flow] + BYTE_W'(upd_size);
      pkt_new  = pkt_tab[upd_flow] + PKT_W'(1);
      sat_new  = 1'b0;
   end
`endif

   // Read snapshot forwards a same-cycle update to the same flow so it is included.
   always_comb begin
      snap_bytes = byte_tab[rd_flow];
      snap_pkts  = pkt_tab[rd_flow];
      snap_sat   = sat_tab[rd_flow];
      if (hit) begin
         snap_bytes = byte_new;
         snap_pkts  = pkt_new;
         snap_sat   = sat_new;
      end
   end

   // Table writes: the INIT sweep zeroes entries, and RUN applies updates; a read-clear wins over a same-flow update.
   always_ff @(posedge clk) begin
      if (!run) begin
         byte_tab[sweep_ptr] <= '0;
         pkt_tab[sweep_ptr]  <= '0;
         sat_tab[sweep_ptr]  <= 1'b0;
      end else begin
         if (upd_go) begin
            byte_tab[upd_flow] <= byte_new;
            pkt_tab[upd_flow]  <= pkt_new;
            sat_tab[upd_flow]  <= sat_new;
         end
         if (rd_go && rd_clr) begin
            byte_tab[rd_flow] <= '0;
            pkt_tab[rd_flow]  <= '0;
            sat_tab[rd_flow]  <= 1'b0;
         end
      end
   end

   // INIT/RUN sequencer: the sweep pointer walks every entry once, then init_done rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INIT;
         sweep_ptr <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               sweep_ptr <= sweep_ptr + FLOW_W'(1);
               if (sweep_ptr == FLOW_W'(NFLOW-1)) begin
                  state     <= RUN;
                  init_done <= 1'b1;
               end
            end
            RUN: begin
               init_done <= 1'b1;
            end
            default: begin
               state     <= INIT;
               sweep_ptr <= '0;
               init_done <= 1'b0;
            end
         endcase
      end
   end

   // Two-stage read response pipeline; the outputs are zero whenever no response is valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_val   <= 1'b0;
         s1_bytes <= '0;
         s1_pkts  <= '0;
         s1_sat   <= 1'b0;
         rd_val   <= 1'b0;
         rd_bytes <= '0;
         rd_pkts  <= '0;
         rd_sat   <= 1'b0;
      end else begin
         s1_val   <= rd_go;
         s1_bytes <= snap_bytes;
         s1_pkts  <= snap_pkts;
         s1_sat   <= snap_sat;
         rd_val   <= s1_val;
         rd_bytes <= s1_val ? s1_bytes : '0;
         rd_pkts  <= s1_val ? s1_pkts : '0;
         rd_sat   <= s1_val ? s1_sat : 1'b0;
      end
   end

endmodule

// File: tb/tb_flow_stat_ctr.sv
// Scoreboard testbench for flow_stat_ctr (BYTE_W=16, so byte saturation and wrap are reachable).
// Reference model: running totals per flow since the last clear, mapped to saturate or wrap at read time.
module tb_flow_stat_ctr;

   localparam int FW = 3;
   localparam int SW = 16;
   localparam int BW = 16;
   localparam int PW = 24;
   localparam longint BMAX = 65535;
   localparam longint PMAX = 16777215;

   typedef struct {
      int           due;
      logic [BW-1:0] b;
      logic [PW-1:0] p;
      logic          s;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          upd_ena = 1'b0;
   logic [FW-1:0] upd_flow = '0;
   logic [SW-1:0] upd_size = '0;
   logic          rd_stb = 1'b0;
   logic [FW-1:0] rd_flow = '0;
   logic          rd_clr = 1'b0;
   logic          rd_val;
   logic [BW-1:0] rd_bytes;
   logic [PW-1:0] rd_pkts;
   logic          rd_sat;
   logic          init_done;

   int     total = 0;
   int     bad = 0;
   int     cyc = 0;
   longint tot_b [8];
   longint tot_p [8];
   exp_t   sb_q [$];

   flow_stat_ctr #(.FLOW_W(FW), .SIZE_W(SW), .BYTE_W(BW), .PKT_W(PW)) dut (
      .clk(clk), .rst(rst),
      .upd_ena(upd_ena), .upd_flow(upd_flow), .upd_size(upd_size),
      .rd_stb(rd_stb), .rd_flow(rd_flow), .rd_clr(rd_clr),
      .rd_val(rd_val), .rd_bytes(rd_bytes), .rd_pkts(rd_pkts), .rd_sat(rd_sat),
      .init_done(init_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t mkExp(input int f);
      exp_t e;
      longint b = tot_b[f];
      longint p = tot_p[f];
      e.due = cyc + 2;
`ifdef FLOW_STAT_SAT_EN
      e.b = BW'((b > BMAX) ? BMAX : b);
      e.p = PW'((p > PMAX) ? PMAX : p);
      e.s = (b > BMAX) || (p > PMAX);
`else
      e.b = BW'(b % (BMAX + 1));
      e.p = PW'(p % (PMAX + 1));
      e.s = 1'b0;
`endif
      return e;
   endfunction

   // One RUN cycle of stimulus; the model absorbs the update before the read, then applies any clear.
   task automatic applyStimulus(input logic ue, input int uf, input int us,
                                input logic rs, input int rf, input logic rc);
      @(negedge clk);
      upd_ena  = ue;
      upd_flow = FW'(uf);
      upd_size = SW'(us);
      rd_stb   = rs;
      rd_flow  = FW'(rf);
      rd_clr   = rc;
      if (ue) begin
         tot_b[uf] += longint'(us);
         tot_p[uf] += 1;
      end
      if (rs) begin
         sb_q.push_back(mkExp(rf));
         if (rc) begin
            tot_b[rf] = 0;
            tot_p[rf] = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
   endtask

   // Reset pulse, then the INIT sweep with updates and reads held active to prove they are ignored.
   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      upd_ena = 1'b0;
      rd_stb = 1'b0;
      rd_clr = 1'b0;
      sb_q.delete();
      for (int f = 0; f < 8; f++) begin
         tot_b[f] = 0;
         tot_p[f] = 0;
      end
      #1;
      checkOutput("rst_rd_val", longint'(rd_val), 0);
      checkOutput("rst_init_done", longint'(init_done), 0);
      @(negedge clk);
      rst = 1'b0;
      upd_ena = 1'b1;
      upd_flow = '0;
      upd_size = SW'(999);
      rd_stb = 1'b1;
      rd_flow = '0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("init_done_edge%0d", i), longint'(init_done), (i == 8) ? 1 : 0);
      end
      upd_ena = 1'b0;
      rd_stb = 1'b0;
   endtask

   // Monitor: pops the scoreboard whenever rd_val shows, and checks idle outputs stay zero.
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            total++;
            bad++;
            $display("[TB] FAIL missing_rd_val: response due cycle %0d not seen by cycle %0d", sb_q[0].due, cyc);
            void'(sb_q.pop_front());
         end
         if (rd_val) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL spurious_rd_val: rd_val=1 required no response (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               checkOutput("rd_latency", longint'(cyc), longint'(e.due));
               checkOutput("rd_bytes", longint'(rd_bytes), longint'(e.b));
               checkOutput("rd_pkts", longint'(rd_pkts), longint'(e.p));
               checkOutput("rd_sat", longint'(rd_sat), longint'(e.s));
            end
         end else begin
            checkOutput("idle_outputs_zero", longint'(rd_bytes) + longint'(rd_pkts) + longint'(rd_sat), 0);
         end
      end
   end

   initial begin
      for (int f = 0; f < 8; f++) begin
         tot_b[f] = 0;
         tot_p[f] = 0;
      end
      doReset();

      // Fresh table reads as zero.
      for (int f = 0; f < 8; f++) applyStimulus(1'b0, 0, 0, 1'b1, f, 1'b0);
      idle(3);

      // Seven back-to-back updates to flow 0, then read it.
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 0, 100, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b1, 0, 1'b0);
      idle(3);

      // Alternating flows 0/1, then read-clear flow 1 in the same cycle as a flow-1 update.
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, i % 2, 100, 1'b0, 0, 1'b0);
      applyStimulus(1'b1, 1, 100, 1'b1, 1, 1'b1);
      applyStimulus(1'b0, 0, 0, 1'b1, 1, 1'b0);
      idle(3);

      // Read-clear of flow 2, then an update in the next cycle.
      applyStimulus(1'b1, 2, 30, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b1, 2, 1'b1);
      applyStimulus(1'b1, 2, 50, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b1, 2, 1'b0);
      idle(3);

      // Two large updates that overflow the 16-bit byte counter of flow 3.
      applyStimulus(1'b1, 3, 40000, 1'b0, 0, 1'b0);
      applyStimulus(1'b1, 3, 40000, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b1, 3, 1'b0);
      idle(3);

      // Reset while a read is in flight: its response must never appear.
      applyStimulus(1'b1, 5, 77, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b1, 5, 1'b0);
      doReset();
      idle(3);

      // Asynchronous reset while rd_val is high forces the outputs low at once.
      applyStimulus(1'b1, 4, 123, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b1, 4, 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
      @(posedge clk);
      #2;
      checkOutput("async_pre_rd_val", longint'(rd_val), 1);
      checkOutput("async_pre_rd_bytes", longint'(rd_bytes), 123);
      rst = 1'b1;
      #1;
      checkOutput("async_rd_val", longint'(rd_val), 0);
      checkOutput("async_rd_bytes", longint'(rd_bytes), 0);
      checkOutput("async_rd_pkts", longint'(rd_pkts), 0);
      checkOutput("async_init_done", longint'(init_done), 0);
      doReset();

      // Randomized traffic with reads, some of them clearing.
      for (int i = 0; i < 400; i++) begin
         logic rs;
         rs = ($urandom_range(0, 3) == 0);
         applyStimulus(logic'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 2000)),
                       rs, int'($urandom_range(0, 7)), logic'($urandom_range(0, 1)));
      end
      for (int f = 0; f < 8; f++) applyStimulus(1'b0, 0, 0, 1'b1, f, 1'b1);
      for (int f = 0; f < 8; f++) applyStimulus(1'b0, 0, 0, 1'b1, f, 1'b0);
      idle(5);

      checkOutput("scoreboard_drained", longint'(sb_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
